// File: rtl/nios_mul_pkg.sv
// Shared constants and types for the multiplier arbiter.
//   MUL_W           : operand / result width of the multiplier cell
//   DEF_MUL_LATENCY : default cell latency in cycles
//   DEF_ID_W        : default requester id width
//   mul_id_t        : requester id type at the default width
package nios_mul_pkg;

   localparam int MUL_W           = 32;
   localparam int DEF_MUL_LATENCY = 1;
   localparam int DEF_ID_W        = 2;

   typedef logic [DEF_ID_W-1:0] mul_id_t;

endpackage

// File: rtl/nios_mul_rr_picker.sv
// Combinational rotating-priority picker.
// Ports:
//   eligible  : requesters that may be granted this cycle
//   rr_ptr    : index with highest priority; priority falls with increasing
//               index, wrapping modulo N
//   grant     : one-hot grant (all zero when nothing is eligible)
//   grant_idx : encoded index of the granted requester (0 when none)
//   grant_vld : some requester was granted
module nios_mul_rr_picker #(
   parameter int N  = 3,
   parameter int IW = 2
) (
   input  logic [N-1:0]  eligible,
   input  logic [IW-1:0] rr_ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          grant_vld
);

   always_comb begin
      int idx;
      idx       = 0;
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      // Walk from the farthest offset down to offset 0 so that the candidate
      // closest to rr_ptr is the last one written and therefore wins.
      for (int j = N - 1; j >= 0; j--) begin
         idx = (int'(rr_ptr) + j) % N;
         if (eligible[idx]) begin
            grant     = N'(1) << idx;
            grant_idx = IW'(idx);
            grant_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/nios_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined 32x32->32 multiplier cell among
// NUM_REQ requesters. One op issued per cycle; each result is returned tagged
// with the owning requester id. A requester has at most one op in flight.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   req                  : per-requester request, held with stable operands
//                          until gnt
//   req_src1, req_src2   : flattened operands, slice i belongs to requester i
//   gnt                  : one-hot issue acknowledge (combinational)
//   A_mul_src1/2         : operands driven to the multiplier cell
//   A_mul_cell_result    : product low word returned by the cell
//   res_valid/id/data    : result strobe, owner id and product low word
//   busy                 : requester i has an op in flight
// Build option:
//   NIOS_MUL_ARB_OUT_REG_EN - register res_valid/res_id/res_data once more,
//   adding one cycle of latency; pending clears on the registered strobe.
module nios_mul_arbiter
   import nios_mul_pkg::*;
#(
   parameter int NUM_REQ     = 3,
   parameter int MUL_LATENCY = DEF_MUL_LATENCY,
   parameter int ID_W        = DEF_ID_W
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*MUL_W-1:0] req_src1,
   input  logic [NUM_REQ*MUL_W-1:0] req_src2,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [MUL_W-1:0]         A_mul_src1,
   output logic [MUL_W-1:0]         A_mul_src2,
   input  logic [MUL_W-1:0]         A_mul_cell_result,
   output logic                     res_valid,
   output logic [ID_W-1:0]          res_id,
   output logic [MUL_W-1:0]         res_data,
   output logic [NUM_REQ-1:0]       busy
);

   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    last_idx;
   logic [NUM_REQ-1:0] pending;
   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] pick_gnt;
   logic [ID_W-1:0]    pick_idx;
   logic               pick_vld;
   logic               issue;
   logic [ID_W-1:0]    sel_idx;

   logic               vld_pipe [MUL_LATENCY];
   logic [ID_W-1:0]    id_pipe  [MUL_LATENCY];

   logic               done_vld;
   logic [ID_W-1:0]    done_id;
   logic [NUM_REQ-1:0] set_mask;
   logic [NUM_REQ-1:0] clr_mask;

   assign eligible = req & ~pending;

   nios_mul_rr_picker #(
      .N  (NUM_REQ),
      .IW (ID_W)
   ) u_picker (
      .eligible  (eligible),
      .rr_ptr    (rr_ptr),
      .grant     (pick_gnt),
      .grant_idx (pick_idx),
      .grant_vld (pick_vld)
   );

   // No grant may leak out while reset is held, even though req is live.
   assign issue = pick_vld & reset_n;
   assign gnt   = reset_n ? pick_gnt : '0;

   // Idle cycles keep the previous requester selected so the cell inputs
   // do not toggle needlessly.
   assign sel_idx    = issue ? pick_idx : last_idx;
   assign A_mul_src1 = req_src1[int'(sel_idx)*MUL_W +: MUL_W];
   assign A_mul_src2 = req_src2[int'(sel_idx)*MUL_W +: MUL_W];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr   <= '0;
         last_idx <= '0;
      end else if (issue) begin
         rr_ptr   <= (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
         last_idx <= pick_idx;
      end
   end

   // Valid/id tag travels alongside the op through the cell.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < MUL_LATENCY; i++) begin
            vld_pipe[i] <= 1'b0;
            id_pipe[i]  <= '0;
         end
      end else begin
         vld_pipe[0] <= issue;
         id_pipe[0]  <= pick_idx;
         for (int i = 1; i < MUL_LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            id_pipe[i]  <= id_pipe[i-1];
         end
      end
   end

`ifdef NIOS_MUL_ARB_OUT_REG_EN
   logic               res_valid_q;
   logic [ID_W-1:0]    res_id_q;
   logic [MUL_W-1:0]   res_data_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         res_valid_q <= 1'b0;
         res_id_q    <= '0;
         res_data_q  <= '0;
      end else begin
         res_valid_q <= vld_pipe[MUL_LATENCY-1];
         res_id_q    <= id_pipe[MUL_LATENCY-1];
         res_data_q  <= A_mul_cell_result;
      end
   end

   assign res_valid = res_valid_q;
   assign res_id    = res_id_q;
   assign res_data  = res_data_q;
`else
   assign res_valid = vld_pipe[MUL_LATENCY-1];
   assign res_id    = id_pipe[MUL_LATENCY-1];
   assign res_data  = A_mul_cell_result;
`endif

   // Pending clears on the strobe the consumer actually sees.
   assign done_vld = res_valid;
   assign done_id  = res_id;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (issue)    set_mask = pick_gnt;
      if (done_vld) clr_mask = NUM_REQ'(1) << done_id;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) pending <= '0;
      else          pending <= (pending & ~clr_mask) | set_mask;
   end

   assign busy = pending;

endmodule

// File: tb/tb_nios_mul_arbiter.sv
module tb_nios_mul_arbiter;

   localparam int NUM_REQ     = 3;
   localparam int MUL_LATENCY = 1;
   localparam int ID_W        = 2;
`ifdef NIOS_MUL_ARB_OUT_REG_EN
   localparam int LAT = MUL_LATENCY + 1;
`else
   localparam int LAT = MUL_LATENCY;
`endif

   logic                  clk = 1'b0;
   logic                  reset_n = 1'b0;
   logic [NUM_REQ-1:0]    req = '0;
   logic [NUM_REQ*32-1:0] req_src1 = '0;
   logic [NUM_REQ*32-1:0] req_src2 = '0;
   logic [NUM_REQ-1:0]    gnt;
   logic [31:0]           A_mul_src1, A_mul_src2, A_mul_cell_result;
   logic                  res_valid;
   logic [ID_W-1:0]       res_id;
   logic [31:0]           res_data;
   logic [NUM_REQ-1:0]    busy;

   always #5 clk = ~clk;

   nios_mul_arbiter #(.NUM_REQ(NUM_REQ), .MUL_LATENCY(MUL_LATENCY), .ID_W(ID_W)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .req               (req),
      .req_src1          (req_src1),
      .req_src2          (req_src2),
      .gnt               (gnt),
      .A_mul_src1        (A_mul_src1),
      .A_mul_src2        (A_mul_src2),
      .A_mul_cell_result (A_mul_cell_result),
      .res_valid         (res_valid),
      .res_id            (res_id),
      .res_data          (res_data),
      .busy              (busy)
   );

   // Behavioural multiplier cell: product of whatever sits on its inputs,
   // delayed MUL_LATENCY cycles.
   logic [31:0] cell_pipe [MUL_LATENCY];
   always @(posedge clk) begin
      cell_pipe[0] <= A_mul_src1 * A_mul_src2;
      for (int i = 1; i < MUL_LATENCY; i++) cell_pipe[i] <= cell_pipe[i-1];
   end
   assign A_mul_cell_result = cell_pipe[MUL_LATENCY-1];

   // Reference model state
   typedef struct {
      int          due;
      int          id;
      logic [31:0] data;
   } op_t;

   op_t         inflight[$];
   bit          m_pend [NUM_REQ];
   int          m_rr;
   int          m_last;
   int          cyc;
   logic [31:0] op_a [NUM_REQ];
   logic [31:0] op_b [NUM_REQ];
   bit          last_gnt [NUM_REQ];

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] rand_word();
      case ($urandom_range(7))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   task automatic drive_ops();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_src1[i*32 +: 32] = op_a[i];
         req_src2[i*32 +: 32] = op_b[i];
      end
   endtask

   task automatic model_reset();
      inflight.delete();
      for (int i = 0; i < NUM_REQ; i++) begin
         m_pend[i]   = 1'b0;
         last_gnt[i] = 1'b0;
      end
      m_rr   = 0;
      m_last = 0;
   endtask

   // Called just after a falling edge with inputs already driven; checks the
   // cycle, advances the model across the rising edge, returns at the next
   // falling edge.
   task automatic run_cycle();
      int                 k;
      logic [NUM_REQ-1:0] exp_gnt;
      logic [NUM_REQ-1:0] exp_busy;
      bit                 exp_rv;
      int                 sel;
      #1;
      k = -1;
      for (int j = 0; j < NUM_REQ; j++) begin
         int idx = (m_rr + j) % NUM_REQ;
         if (k < 0 && req[idx] && !m_pend[idx]) k = idx;
      end
      exp_gnt  = (k >= 0) ? (NUM_REQ'(1) << k) : '0;
      exp_busy = '0;
      for (int i = 0; i < NUM_REQ; i++) exp_busy[i] = m_pend[i];
      sel = (k >= 0) ? k : m_last;
      check_eq("gnt", 64'(gnt), 64'(exp_gnt));
      check_eq("busy", 64'(busy), 64'(exp_busy));
      check_eq("mul_src1", 64'(A_mul_src1), 64'(op_a[sel]));
      check_eq("mul_src2", 64'(A_mul_src2), 64'(op_b[sel]));
      exp_rv = (inflight.size() > 0) && (inflight[0].due == cyc);
      check_eq("res_valid", 64'(res_valid), 64'(exp_rv));
      if (exp_rv) begin
         check_eq("res_id", 64'(res_id), 64'(inflight[0].id));
         check_eq("res_data", 64'(res_data), 64'(inflight[0].data));
      end
      @(posedge clk);
      if (exp_rv) begin
         m_pend[inflight[0].id] = 1'b0;
         void'(inflight.pop_front());
      end
      for (int i = 0; i < NUM_REQ; i++) last_gnt[i] = (i == k);
      if (k >= 0) begin
         op_t o;
         o.due  = cyc + LAT;
         o.id   = k;
         o.data = op_a[k] * op_b[k];
         inflight.push_back(o);
         m_pend[k] = 1'b1;
         m_rr      = (k + 1) % NUM_REQ;
         m_last    = k;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic rand_inputs();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req[i] && !last_gnt[i]) begin
            // Waiting for grant: operands stay put, occasional withdrawal.
            if ($urandom_range(15) == 0) req[i] = 1'b0;
         end else begin
            req[i]  = 1'($urandom_range(1));
            op_a[i] = rand_word();
            op_b[i] = rand_word();
         end
      end
      drive_ops();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_gnt"}, 64'(gnt), 64'(0));
      check_eq({tag, "_res_valid"}, 64'(res_valid), 64'(0));
      check_eq({tag, "_res_id"}, 64'(res_id), 64'(0));
      check_eq({tag, "_busy"}, 64'(busy), 64'(0));
   endtask

   initial begin
      cyc = 0;
      model_reset();
      for (int i = 0; i < NUM_REQ; i++) begin
         op_a[i] = '0;
         op_b[i] = '0;
      end
      drive_ops();

      // Reset with live requests: outputs must stay quiet.
      req = '1;
      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("rst");
      req = '0;
      reset_n = 1'b1;

      // Single request
      op_a[1] = 32'h0001_0003;
      op_b[1] = 32'h0000_0005;
      drive_ops();
      req = 3'b010;
      run_cycle();
      req = '0;
      run_cycle();
      run_cycle();

      // All requesters held continuously
      op_a[0] = 32'hFFFF_FFFF; op_b[0] = 32'h2;
      op_a[1] = 32'h1234_5678; op_b[1] = 32'h10;
      op_a[2] = 32'h8000_0001; op_b[2] = 32'h8000_0001;
      drive_ops();
      req = 3'b111;
      repeat (8) run_cycle();
      req = '0;
      repeat (3) run_cycle();

      // One requester held: issues every other cycle, completion collisions
      req = 3'b001;
      repeat (6) run_cycle();
      req = 3'b100;
      repeat (5) run_cycle();
      req = '0;
      repeat (3) run_cycle();

      // Reset while ops are in flight
      req = 3'b011;
      run_cycle();
      run_cycle();
      req = '0;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      req = 3'b110;
      repeat (4) run_cycle();
      req = '0;
      repeat (3) run_cycle();

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         rand_inputs();
         run_cycle();
      end
      req = '0;
      repeat (LAT + 2) run_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
